// File: rtl/wait_timer.sv
// wait_timer: retriggerable delay timer with clock prescaler, loadable tick
// count, one-shot / periodic modes, abort and a sticky done / ack handshake.
module wait_timer #(
    parameter int WIDTH         = 32,
    parameter int DEFAULT_TICKS = 1000000,
    parameter int PRESCALE      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             periodic,
    input  logic             use_load,
    input  logic [WIDTH-1:0] load_ticks,
    output logic             busy,
    output logic             done,
    output logic             expire,
    output logic [WIDTH-1:0] count
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] DEF_TICKS = WIDTH'(DEFAULT_TICKS);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sel_ticks;
    logic [WIDTH-1:0] start_target;
    logic             wrap;

    // Target chosen at start; a zero count is treated as a single tick.
    always_comb begin
        sel_ticks    = use_load ? load_ticks : DEF_TICKS;
        start_target = (sel_ticks == '0) ? ONE : sel_ticks;
    end

    // Outputs are pure decodes of registered state (no input-to-output path).
    always_comb begin
        wrap   = (presc_q == PRESC_LAST);
        expire = (state_q == RUN) && (remaining_q == ONE) && wrap;
        busy   = (state_q == RUN);
        done   = done_q;
        count  = remaining_q;
    end

    // Next state: abort > start > expiry > ack (reset handled in the flops).
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        done_d      = done_q;

        if (state_q == RUN && abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            presc_d     = '0;
        end else if (start && !abort) begin
            // Launch or retrigger; wins over a coincident expiry.
            state_d     = RUN;
            target_d    = start_target;
            remaining_d = start_target;
            presc_d     = '0;
            mode_d      = periodic;
            done_d      = 1'b0;
        end else if (state_q == RUN) begin
            if (!wrap) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d = '0;
                if (remaining_q != ONE) begin
                    remaining_d = remaining_q - ONE;
                end else if (mode_q) begin
                    remaining_d = target_q;
                end else begin
                    state_d     = DONE;
                    remaining_d = '0;
                    done_d      = 1'b1;
                end
            end
        end else if (state_q == DONE && ack) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_wait_timer.sv
// Bench for wait_timer: two instances (prescale 1 and 4) share stimulus and
// are compared every cycle against an elapsed-time model of the timer.
module tb_wait_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, abort, ack, periodic, use_load;
    logic [W-1:0] load_ticks;

    logic         busy_a, done_a, expire_a;
    logic [W-1:0] count_a;
    logic         busy_b, done_b, expire_b;
    logic [W-1:0] count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wait_timer #(.WIDTH(W), .DEFAULT_TICKS(7), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .periodic(periodic), .use_load(use_load), .load_ticks(load_ticks),
        .busy(busy_a), .done(done_a), .expire(expire_a), .count(count_a));

    wait_timer #(.WIDTH(W), .DEFAULT_TICKS(3), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .periodic(periodic), .use_load(use_load), .load_ticks(load_ticks),
        .busy(busy_b), .done(done_b), .expire(expire_b), .count(count_b));

    // Model: per instance, whether a run is active, cycles elapsed since the
    // accepting start (1 in the first RUN cycle), tick count N and mode.
    int m_p   [2] = '{1, 4};
    int m_def [2] = '{7, 3};
    bit m_run [2];
    bit m_done[2];
    bit m_per [2];
    int m_n   [2];
    int m_e   [2];

    function automatic bit exp_expire(int i);
        return m_run[i] && (m_e[i] % (m_n[i] * m_p[i]) == 0);
    endfunction

    function automatic int exp_count(int i);
        if (!m_run[i]) return 0;
        return m_n[i] - (((m_e[i] - 1) % (m_n[i] * m_p[i])) / m_p[i]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy_p1",   int'(busy_a),   int'(m_run[0]));
        chk("done_p1",   int'(done_a),   int'(m_done[0]));
        chk("expire_p1", int'(expire_a), int'(exp_expire(0)));
        chk("count_p1",  int'(count_a),  exp_count(0));
        chk("busy_p4",   int'(busy_b),   int'(m_run[1]));
        chk("done_p4",   int'(done_b),   int'(m_done[1]));
        chk("expire_p4", int'(expire_b), int'(exp_expire(1)));
        chk("count_p4",  int'(count_b),  exp_count(1));
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_run[i] = 0; m_done[i] = 0; m_per[i] = 0; m_n[i] = 0; m_e[i] = 0;
            end else if (start && !abort) begin
                m_n[i]    = use_load ? int'(load_ticks) : m_def[i];
                if (m_n[i] == 0) m_n[i] = 1;
                m_per[i]  = periodic;
                m_run[i]  = 1;
                m_done[i] = 0;
                m_e[i]    = 1;
            end else if (m_run[i]) begin
                if (abort) m_run[i] = 0;
                else if (exp_expire(i) && !m_per[i]) begin
                    m_run[i] = 0; m_done[i] = 1;
                end else m_e[i]++;
            end else if (m_done[i] && ack) begin
                m_done[i] = 0;
            end
        end
    endtask

    // Check the current cycle, then advance one clock with the current inputs.
    task automatic step();
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; abort = 0; ack = 0;
        periodic = 0; use_load = 1; load_ticks = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_start(input int ld, input bit per, input bit ul);
        start = 1; load_ticks = W'(ld); periodic = per; use_load = ul;
        step();
        start = 0; periodic = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_per[i] = 0; m_n[i] = 0; m_e[i] = 0;
        end
        step();                         // reset values
        reset = 0;
        run_idle(2);

        // One-shot basic: load 5, hold past done, then ack
        pulse_start(5, 0, 1);
        run_idle(8);
        ack = 1; step(); ack = 0;
        run_idle(3);
        do_reset();

        // Default tick count (3 at prescale 4 -> expire in cycle 12)
        pulse_start(0, 0, 0);
        run_idle(16);
        ack = 1; step(); ack = 0;
        do_reset();

        // Periodic load 4, abort in cycle 14
        pulse_start(4, 1, 1);
        run_idle(13);
        abort = 1; step(); abort = 0;
        run_idle(6);
        do_reset();

        // Zero load coerced to one tick
        pulse_start(0, 0, 1);
        run_idle(6);
        do_reset();

        // Retrigger: load 10, restart in cycle 6 with load 2
        pulse_start(10, 0, 1);
        run_idle(5);
        pulse_start(2, 0, 1);
        run_idle(12);
        do_reset();

        // abort and start together while running
        pulse_start(6, 0, 1);
        run_idle(2);
        abort = 1; start = 1; load_ticks = W'(3); step(); abort = 0; start = 0;
        run_idle(4);
        do_reset();

        // start coincident with expiry (cycle 3 of a 3-tick run at prescale 1)
        pulse_start(3, 0, 1);
        run_idle(2);
        pulse_start(3, 0, 1);
        run_idle(14);
        do_reset();

        // Reset mid-count (cycle 3 of 5)
        pulse_start(5, 0, 1);
        run_idle(2);
        reset = 1; step(); reset = 0;
        run_idle(8);

        // start with ack in DONE
        pulse_start(2, 0, 1);
        run_idle(3);
        ack = 1; start = 1; load_ticks = W'(2); step(); ack = 0; start = 0;
        run_idle(12);
        do_reset();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset      = ($urandom_range(0, 149) == 0);
            start      = ($urandom_range(0, 11) == 0);
            abort      = ($urandom_range(0, 24) == 0);
            ack        = ($urandom_range(0, 3) == 0);
            periodic   = $urandom_range(0, 1);
            use_load   = ($urandom_range(0, 3) != 0);
            load_ticks = W'($urandom_range(0, 6));
            step();
        end
        idle_inputs();
        run_idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
